powlib_busarb: RTL and testbench
================================

Name: powlib_busarb

Overview:
Round-robin arbiter with quantum locking. It shares one bus reading interface (data + address, valid/ready) among B_WRS bus writing interfaces. It sits in front of a bus FIFO or crossbar lane where fixed lowest-index priority would starve high-index writers. Each granted writer may hold the output for up to Q consecutive beats, then ownership rotates. The output is a single register stage with full throughput.

Parameters:
B_WRS, 4, number of bus writing interfaces (>=2)
B_AW, 2, bus address width
B_DW, 4, bus data width
Q, 4, max consecutive beats per owner before forced rotation (>=1; Q=1 gives pure round robin)
ID, "BUSARB", string identifier
EDBG, 0, enable debug display of each grant

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
wrdatas  input  B_WRS*B_DW  write datas, writer i at [i*B_DW+:B_DW]
wraddrs  input  B_WRS*B_AW  write addresses, writer i at [i*B_AW+:B_AW]
wrvlds  input  B_WRS  write valids
wrrdys  output  B_WRS  write readies (combinational, at most one bit set)
rddata  output  B_DW  read data (registered)
rdaddr  output  B_AW  read address (registered)
rdvld  output  1  read valid (registered)
rdrdy  input  1  read ready
rdsel  output  B_WRS  one-hot source of the current output beat (registered)

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-low.
- Reset (rst=0, takes effect immediately, independent of clk): rdvld=0, rddata=0, rdaddr=0, rdsel=0, ptr=0, cnt=0, own=0, state=IDLE.
- free = !rdvld || rdrdy. The output register can load when free=1.
- State machine has two states: IDLE and LOCK.
- Grant index g, computed combinationally:
  - LOCK with wrvlds[own]=1: g=own.
  - Otherwise: g is the first i with wrvlds[i]=1, searching ptr, ptr+1, ... and wrapping B_WRS-1 -> 0.
  - No valid writer: no grant.
- wrrdys[g] = free. All other wrrdys bits are 0. A transfer occurs when wrvlds[g] && wrrdys[g].
- Transfer on clock edge:
  - rddata/rdaddr load the data/address of writer g.
  - rdvld=1, rdsel=onehot(g).
  - Latency is 1 cycle from transfer to rdvld. Throughput is 1 beat/cycle.
- No transfer but rdrdy=1: rdvld clears to 0; rddata/rdaddr/rdsel hold their values.
- Back-pressure: while rdvld=1 and rdrdy=0, rddata/rdaddr/rdsel/rdvld are stable and all wrrdys=0.
- Quantum counter cnt (width clog2(Q), minimum 1), updated on a transfer from g:
  - If cnt==Q-1: state->IDLE, cnt->0, ptr->(g+1) mod B_WRS.
  - Else: state->LOCK, own->g, cnt->cnt+1.
- Early release: in LOCK with wrvlds[own]=0, g re-arbitrates that same cycle starting from (own+1) mod B_WRS, so there is no bubble.
  - If a transfer occurs: apply the quantum update for the new g. Its count starts from 0, so state goes LOCK with cnt=1, or IDLE if Q=1.
  - If no transfer: state->IDLE, ptr->(own+1) mod B_WRS, cnt->0.
- Lock is kept under back-pressure: in LOCK, own is unchanged while free=0, even if other writers are valid.
- Stalled owner: if free=1 and wrvlds[own]=1, own keeps the grant until the quantum expires.
- Writers must hold wrdata/wraddr/wrvld stable until their wrrdy is seen.
- Pointer arithmetic wraps modulo B_WRS; B_WRS need not be a power of two.
- EDBG=1: $display of ID, time, g, address and data on each transfer.

Test Plan:
- Q=4, only writer 1 streams 5 beats (data 1..5), rdrdy=1 -> rdvld high from the cycle after the first accept; data 1..5 back-to-back, rdsel=4'b0010; no bubble at the quantum wrap (rotation finds writer 1 again).
- Q=2, all four writers continuously valid, rdrdy=1 -> rdsel sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001; each writer gets exactly 2 of every 8 beats.
- Q=4, writer 0 streaming, rdrdy=0 for 3 cycles mid-stream -> wrrdys=0000 and rddata held; after rdrdy=1 stream resumes with no lost or duplicated beat; cnt continues from its pre-stall value.
- Q=4, writer 0 valid for 1 beat only, writer 2 valid throughout -> the cycle after writer 0 drops, writer 2 is granted with no idle cycle; writer 2 then holds for 4 beats.
- Q=1, writers 3 and 0 valid, ptr reaches 3 -> grants alternate 3,0,3,0 (wrap 3->0 verified); B_WRS=3 build repeats with the 2->0 wrap.
- rst driven low mid-stream with rdvld=1, asynchronous to clk -> rdvld, rdsel, rddata go 0 before the next edge; after release with writers 1 and 2 valid, first grant goes to writer 1 (ptr=0 search).

Source files
------------

// File: rtl/powlib_busarb.sv
// Round-robin bus arbiter with quantum locking: B_WRS writers share one registered
// output stage; an owner keeps the bus for up to Q consecutive beats before rotating.
module powlib_busarb #(
    parameter int    B_WRS = 4,
    parameter int    B_AW  = 2,
    parameter int    B_DW  = 4,
    parameter int    Q     = 4,
    parameter string ID    = "BUSARB",
    parameter int    EDBG  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [B_WRS*B_DW-1:0]   wrdatas,
    input  logic [B_WRS*B_AW-1:0]   wraddrs,
    input  logic [B_WRS-1:0]        wrvlds,
    output logic [B_WRS-1:0]        wrrdys,
    output logic [B_DW-1:0]         rddata,
    output logic [B_AW-1:0]         rdaddr,
    output logic                    rdvld,
    input  logic                    rdrdy,
    output logic [B_WRS-1:0]        rdsel
);

    localparam int PW = (B_WRS > 1) ? $clog2(B_WRS) : 1;
    localparam int CW = (Q > 1) ? $clog2(Q) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    localparam logic [CW-1:0] CNT_LAST = CW'(Q - 1);

    logic [0:0]       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    own;
    logic [CW-1:0]    cnt;

    logic             hold;
    logic [PW-1:0]    start;
    logic             found;
    logic [PW-1:0]    g;
    logic             free;
    logic             xfer;
    logic [CW-1:0]    base;
    logic [B_WRS-1:0] sel_nxt;
    int               idx;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        if (int'(v) == B_WRS - 1) begin
            return '0;
        end
        return v + PW'(1);
    endfunction

    // An owner with its valid still up keeps the grant; otherwise search round-robin,
    // starting just past the owner so an early release costs no idle cycle.
    always_comb begin
        hold  = (state == LOCK) && wrvlds[own];
        start = (state == LOCK) ? wrap_inc(own) : ptr;
        found = 1'b0;
        g     = '0;
        idx   = 0;
        if (hold) begin
            found = 1'b1;
            g     = own;
        end else begin
            for (int k = 0; k < B_WRS; k++) begin
                idx = int'(start) + k;
                if (idx >= B_WRS) begin
                    idx = idx - B_WRS;
                end
                if (!found && wrvlds[idx[PW-1:0]]) begin
                    found = 1'b1;
                    g     = idx[PW-1:0];
                end
            end
        end
    end

    always_comb begin
        free    = !rdvld || rdrdy;
        xfer    = found && free;
        base    = hold ? cnt : '0;
        wrrdys  = '0;
        sel_nxt = '0;
        if (found) begin
            wrrdys[g]  = free;
            sel_nxt[g] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rddata <= '0;
            rdaddr <= '0;
            rdvld  <= 1'b0;
            rdsel  <= '0;
        end else if (xfer) begin
            rddata <= wrdatas[int'(g)*B_DW +: B_DW];
            rdaddr <= wraddrs[int'(g)*B_AW +: B_AW];
            rdvld  <= 1'b1;
            rdsel  <= sel_nxt;
        end else if (rdrdy) begin
            rdvld  <= 1'b0;
        end
    end

    // A newly granted writer counts from zero; the owner continues from its count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            own   <= '0;
            cnt   <= '0;
        end else if (xfer) begin
            if (base == CNT_LAST) begin
                state <= IDLE;
                cnt   <= '0;
                ptr   <= wrap_inc(g);
            end else begin
                state <= LOCK;
                own   <= g;
                cnt   <= base + CW'(1);
            end
        end else if ((state == LOCK) && !wrvlds[own]) begin
            state <= IDLE;
            ptr   <= wrap_inc(own);
            cnt   <= '0;
        end
    end

endmodule

// File: tb/tb_powlib_busarb.sv
// Directed scoreboard bench for powlib_busarb: Q=4 main instance plus Q=2 and
// three-writer Q=1 instances for rotation and wrap checks.
module tb_powlib_busarb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [15:0] q4_wrdatas;
    logic [7:0]  q4_wraddrs;
    logic [3:0]  q4_wrvlds, q4_wrrdys, q4_rddata, q4_rdsel;
    logic [1:0]  q4_rdaddr;
    logic        q4_rdvld, q4_rdrdy;

    logic [15:0] q2_wrdatas;
    logic [7:0]  q2_wraddrs;
    logic [3:0]  q2_wrvlds, q2_wrrdys, q2_rddata, q2_rdsel;
    logic [1:0]  q2_rdaddr;
    logic        q2_rdvld;

    logic [11:0] w3_wrdatas;
    logic [5:0]  w3_wraddrs;
    logic [2:0]  w3_wrvlds, w3_wrrdys, w3_rdsel;
    logic [3:0]  w3_rddata;
    logic [1:0]  w3_rdaddr;
    logic        w3_rdvld;

    logic        aux_rdrdy;

    int          errors;
    int          checks;
    int          rem[4];
    logic [3:0]  nxt[4];
    logic [9:0]  exp_q4[$];
    logic [9:0]  exp_q2[$];
    logic [9:0]  exp_w3[$];

    powlib_busarb #(.B_WRS(4), .B_AW(2), .B_DW(4), .Q(4)) u_q4 (
        .clk(clk), .rst(rst), .wrdatas(q4_wrdatas), .wraddrs(q4_wraddrs),
        .wrvlds(q4_wrvlds), .wrrdys(q4_wrrdys), .rddata(q4_rddata), .rdaddr(q4_rdaddr),
        .rdvld(q4_rdvld), .rdrdy(q4_rdrdy), .rdsel(q4_rdsel)
    );

    powlib_busarb #(.B_WRS(4), .B_AW(2), .B_DW(4), .Q(2)) u_q2 (
        .clk(clk), .rst(rst), .wrdatas(q2_wrdatas), .wraddrs(q2_wraddrs),
        .wrvlds(q2_wrvlds), .wrrdys(q2_wrrdys), .rddata(q2_rddata), .rdaddr(q2_rdaddr),
        .rdvld(q2_rdvld), .rdrdy(aux_rdrdy), .rdsel(q2_rdsel)
    );

    powlib_busarb #(.B_WRS(3), .B_AW(2), .B_DW(4), .Q(1)) u_w3 (
        .clk(clk), .rst(rst), .wrdatas(w3_wrdatas), .wraddrs(w3_wraddrs),
        .wrvlds(w3_wrvlds), .wrrdys(w3_wrrdys), .rddata(w3_rddata), .rdaddr(w3_rdaddr),
        .rdvld(w3_rdvld), .rdrdy(aux_rdrdy), .rdsel(w3_rdsel)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic updateWriters();
        for (int i = 0; i < 4; i++) begin
            q4_wrdatas[i*4 +: 4] = nxt[i];
            q4_wraddrs[i*2 +: 2] = 2'(i);
            q4_wrvlds[i]         = (rem[i] > 0);
        end
    endtask

    task automatic applyStimulus(input int wr, input int beats, input logic [3:0] first);
        rem[wr] = beats;
        nxt[wr] = first;
        updateWriters();
    endtask

    // Scoreboard pops happen on the falling edge, where the output handshake is stable.
    task automatic tick();
        logic [3:0] acc;
        @(negedge clk);
        acc = q4_wrvlds & q4_wrrdys;
        if (q4_rdvld && q4_rdrdy) begin
            if (exp_q4.size() > 0) begin
                checkOutput("q4_beat", {q4_rdsel, q4_rdaddr, q4_rddata}, exp_q4.pop_front());
            end else begin
                checkOutput("q4_unexpected_beat", {q4_rdsel, q4_rdaddr, q4_rddata}, 10'h0);
            end
        end
        if (q2_rdvld && exp_q2.size() > 0) begin
            checkOutput("q2_beat", {q2_rdsel, q2_rdaddr, q2_rddata}, exp_q2.pop_front());
        end
        if (w3_rdvld && exp_w3.size() > 0) begin
            checkOutput("w3_beat", {1'b0, w3_rdsel, w3_rdaddr, w3_rddata}, exp_w3.pop_front());
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i] && rem[i] > 0) begin
                rem[i] = rem[i] - 1;
                nxt[i] = nxt[i] + 4'd1;
            end
        end
        updateWriters();
    endtask

    task automatic waitDrain(input string tag, input int want);
        int n;
        n = 0;
        while ((exp_q4.size() + exp_q2.size() + exp_w3.size()) > 0 && n < 40) begin
            tick();
            n++;
        end
        checkOutput(tag, n, want);
    endtask

    task automatic doReset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0;
            nxt[i] = '0;
        end
        updateWriters();
        q2_wrvlds = '0;
        w3_wrvlds = '0;
        q4_rdrdy  = 1'b1;
        exp_q4.delete();
        exp_q2.delete();
        exp_w3.delete();
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] s;
        errors     = 0;
        checks     = 0;
        rst        = 1'b0;
        q4_rdrdy   = 1'b1;
        aux_rdrdy  = 1'b1;
        q2_wrdatas = {4'd7, 4'd6, 4'd5, 4'd4};
        q2_wraddrs = 8'b11_10_01_00;
        q2_wrvlds  = '0;
        w3_wrdatas = {4'd6, 4'd5, 4'd4};
        w3_wraddrs = 6'b10_01_00;
        w3_wrvlds  = '0;
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0;
            nxt[i] = '0;
        end
        updateWriters();
        #1;
        checkOutput("reset_rdvld", q4_rdvld, 1'b0);
        checkOutput("reset_rdsel", q4_rdsel, 4'b0000);
        checkOutput("reset_rddata", q4_rddata, 4'h0);
        checkOutput("reset_rdaddr", q4_rdaddr, 2'b00);
        tick();
        tick();
        rst = 1'b1;

        $display("[TB] single writer stream across quantum wrap");
        applyStimulus(1, 5, 4'd1);
        #1;
        checkOutput("t1_wrrdys", q4_wrrdys, 4'b0010);
        for (int d = 1; d <= 5; d++) exp_q4.push_back({4'b0010, 2'd1, 4'(d)});
        waitDrain("t1_drain_cycles", 6);
        doReset();

        $display("[TB] Q=2 rotation with all writers valid");
        for (int k = 0; k < 9; k++) begin
            s = 4'b0001 << ((k / 2) % 4);
            exp_q2.push_back({s, 2'((k / 2) % 4), 4'((k / 2) % 4 + 4)});
        end
        q2_wrvlds = 4'b1111;
        waitDrain("q2_drain_cycles", 10);
        doReset();

        $display("[TB] three writers Q=1 wrap 2->0");
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) exp_w3.push_back({4'b0001, 2'd0, 4'd4});
            else            exp_w3.push_back({4'b0100, 2'd2, 4'd6});
        end
        w3_wrvlds = 3'b101;
        waitDrain("w3_drain_cycles", 7);
        doReset();

        $display("[TB] back-pressure mid-stream");
        applyStimulus(0, 4, 4'd1);
        applyStimulus(2, 2, 4'd9);
        for (int d = 1; d <= 4; d++) exp_q4.push_back({4'b0001, 2'd0, 4'(d)});
        exp_q4.push_back({4'b0100, 2'd2, 4'd9});
        exp_q4.push_back({4'b0100, 2'd2, 4'd10});
        tick();
        tick();
        q4_rdrdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("t3_hold_wrrdys", q4_wrrdys, 4'b0000);
            checkOutput("t3_hold_rddata", q4_rddata, 4'd2);
            checkOutput("t3_hold_rdsel", q4_rdsel, 4'b0001);
        end
        q4_rdrdy = 1'b1;
        waitDrain("t3_drain_cycles", 5);
        doReset();

        $display("[TB] early release hands over without a bubble");
        applyStimulus(0, 1, 4'd1);
        applyStimulus(2, 5, 4'd9);
        applyStimulus(3, 1, 4'd15);
        exp_q4.push_back({4'b0001, 2'd0, 4'd1});
        for (int d = 9; d <= 12; d++) exp_q4.push_back({4'b0100, 2'd2, 4'(d)});
        exp_q4.push_back({4'b1000, 2'd3, 4'd15});
        exp_q4.push_back({4'b0100, 2'd2, 4'd13});
        waitDrain("t4_drain_cycles", 8);
        doReset();

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(1, 20, 4'd1);
        for (int d = 1; d <= 5; d++) exp_q4.push_back({4'b0010, 2'd1, 4'(d)});
        for (int k = 0; k < 6; k++) tick();
        checkOutput("t6_pre_rdvld", q4_rdvld, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_async_rdvld", q4_rdvld, 1'b0);
        checkOutput("t6_async_rdsel", q4_rdsel, 4'b0000);
        checkOutput("t6_async_rddata", q4_rddata, 4'h0);
        checkOutput("t6_async_rdaddr", q4_rdaddr, 2'b00);
        for (int i = 0; i < 4; i++) rem[i] = 0;
        updateWriters();
        exp_q4.delete();
        tick();
        rst = 1'b1;
        applyStimulus(1, 2, 4'd5);
        applyStimulus(2, 1, 4'd9);
        exp_q4.push_back({4'b0010, 2'd1, 4'd5});
        exp_q4.push_back({4'b0010, 2'd1, 4'd6});
        exp_q4.push_back({4'b0100, 2'd2, 4'd9});
        waitDrain("t6_drain_cycles", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
